sio_host_seq: RTL

SIO_HOST_SEQ -- requirements
Module: sio_host_seq

---
 rtl/sio_pkg.sv | 14 +
 rtl/sio_cmd_fifo.sv | 49 ++++
 rtl/sio_host_seq.sv | 107 ++++++++++
 3 files changed

// File: rtl/sio_pkg.sv
// Shared sio definitions: host word widths, minimum turnaround and the
// sequencer FSM encoding.
package sio_pkg;
  localparam int SIO_NBT      = 40;
  localparam int SIO_NBR      = 32;
  // Host stage STATE_END is 25; its response is valid one cycle later.
  localparam int SIO_TURN_MIN = 26;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_CAPT = 2'd2
  } sio_state_e;
endpackage

// File: rtl/sio_cmd_fifo.sv
// Single-clock command FIFO with count-based full/empty and a registered-free
// head output (no fall-through: an entry is visible the cycle after its push).
module sio_cmd_fifo #(
  parameter int W     = 40,
  parameter int DEPTH = 4
) (
  input  logic         c,
  input  logic         r,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_count;
  logic          w_push, w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rp];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge c) begin
    if (r) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is deliberately not reset; pointers alone define validity.
  always_ff @(posedge c) begin
    if (w_push && !r) r_mem[r_wp] <= i_din;
  end
endmodule

// File: rtl/sio_host_seq.sv
// Host command sequencer: queues {addr,data} commands, issues one at a time to
// the sio_host stage and captures its reply TURN cycles after the issue strobe.
module sio_host_seq
  import sio_pkg::*;
#(
  parameter int NBT   = SIO_NBT,
  parameter int NBR   = SIO_NBR,
  parameter int DEPTH = 4,
  parameter int TURN  = 32
) (
  input  logic           c,
  input  logic           r,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [7:0]     cmd_addr,
  input  logic [31:0]    cmd_data,
  output logic           wvalid,
  output logic [NBT-1:0] wdata,
  input  logic [NBR-1:0] rdata,
  output logic           rsp_valid,
  output logic [7:0]     rsp_addr,
  output logic [NBR-1:0] rsp_data,
  output logic           busy
);
  localparam int CW = $clog2(TURN);

  sio_state_e     r_state, w_nstate;
  logic [CW-1:0]  r_cnt;
  logic [7:0]     r_addr;
  logic           r_wvalid, r_rsp_valid;
  logic [NBT-1:0] r_wdata;
  logic [7:0]     r_rsp_addr;
  logic [NBR-1:0] r_rsp_data;
  logic [NBT-1:0] w_head, w_din;
  logic           w_full, w_empty, w_pop, w_capt;

  assign w_din = {cmd_addr, cmd_data};

  sio_cmd_fifo #(.W(NBT), .DEPTH(DEPTH)) u_fifo (
    .c       (c),
    .r       (r),
    .i_push  (cmd_valid),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge c) begin
    if (r) r_state <= ST_IDLE;
    else   r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    w_pop    = 1'b0;
    w_capt   = 1'b0;
    case (r_state)
      ST_IDLE: if (!w_empty) begin
        w_pop    = 1'b1;
        w_nstate = ST_WAIT;
      end
      ST_WAIT: if (r_cnt == CW'(TURN-2)) w_nstate = ST_CAPT;
      ST_CAPT: begin
        w_capt   = 1'b1;
        w_nstate = ST_IDLE;
      end
      default: w_nstate = ST_IDLE;
    endcase
  end

  always_ff @(posedge c) begin
    if (r) begin
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wvalid    <= 1'b0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_addr  <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_wvalid    <= w_pop;
      r_rsp_valid <= w_capt;
      if (w_pop) begin
        r_wdata <= w_head;
        r_addr  <= w_head[NBT-1 -: 8];
        r_cnt   <= '0;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_capt) begin
        r_rsp_data <= rdata;
        r_rsp_addr <= r_addr;
      end
    end
  end

  assign cmd_ready = !w_full;
  assign wvalid    = r_wvalid;
  assign wdata     = r_wdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_addr  = r_rsp_addr;
  assign rsp_data  = r_rsp_data;
  // Stays high through the response strobe so it drops the cycle after it.
  assign busy      = !w_empty || (r_state != ST_IDLE) || r_rsp_valid;
endmodule
